// File: rtl/modn_counter_bcd.sv
// Loadable modulo-N up/down counter with prescaler and terminal-count strobe,
// plus a one-bit-per-cycle shift-add-3 converter that tracks the count as BCD.
module modn_counter_bcd #(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 200,
    parameter int DIGITS   = 3,
    parameter int PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      load_val,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid
);

    localparam int BW = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [IW-1:0]    IDX_TOP = IW'(WIDTH - 1);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    function automatic longint pow10(input int n);
        longint r;
        r = 64'sd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'sd10;
        end
        return r;
    endfunction

    // Digit-wise +3 correction applied before each shift of the double-dabble.
    function automatic logic [BW-1:0] add3(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = v[4*d +: 4] + 4'd3;
            end else begin
                r[4*d +: 4] = v[4*d +: 4];
            end
        end
        return r;
    endfunction

    if (MODULUS < 2 || longint'(MODULUS) > (64'sd1 <<< WIDTH)) begin : g_bad_modulus
        $error("modn_counter_bcd: MODULUS must lie in 2..2**WIDTH");
    end
    if (pow10(DIGITS) < longint'(MODULUS)) begin : g_bad_digits
        $error("modn_counter_bcd: DIGITS too small for MODULUS");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("modn_counter_bcd: PRESCALE must be at least 1");
    end

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} conv_state_e;

    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic [PW-1:0]    pre_q,   pre_d;
    logic             tc_q,    tc_d;
    logic             step_s;

    conv_state_e      state_q, state_d;
    logic [WIDTH-1:0] snap_q,  snap_d;
    logic [BW-1:0]    sr_q,    sr_d;
    logic [IW-1:0]    idx_q,   idx_d;
    logic [BW-1:0]    bcd_q,   bcd_d;
    logic             valid_q, valid_d;
    logic [BW-1:0]    adj_s;
    logic [BW-1:0]    shifted_s;
    logic             changed_s;

    // Prescaler, count and terminal-count next state.
    always_comb begin
        cnt_d  = cnt_q;
        pre_d  = pre_q;
        tc_d   = 1'b0;
        step_s = 1'b0;
        case (mode)
            MODE_UP, MODE_DOWN: begin
                if (en) begin
                    if (pre_q == PRE_MAX) begin
                        pre_d  = '0;
                        step_s = 1'b1;
                    end else begin
                        pre_d = pre_q + PW'(1);
                    end
                end else begin
                    pre_d = pre_q;
                end
                if (step_s && mode == MODE_UP) begin
                    if (cnt_q == MAX_CNT) begin
                        cnt_d = '0;
                        tc_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end else if (step_s) begin
                    if (cnt_q == '0) begin
                        cnt_d = MAX_CNT;
                        tc_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            MODE_LOAD: begin
                cnt_d = (load_val > MAX_CNT) ? MAX_CNT : load_val;
                pre_d = '0;
            end
            MODE_HOLD: begin
                cnt_d = cnt_q;
                pre_d = pre_q;
            end
            default: begin
                cnt_d = cnt_q;
                pre_d = pre_q;
            end
        endcase
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            pre_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pre_q <= pre_d;
            tc_q  <= tc_d;
        end
    end

    assign changed_s = (cnt_q != snap_q);
    assign adj_s     = add3(sr_q);
    assign shifted_s = {adj_s[BW-2:0], snap_q[idx_q]};

    // Converter state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Converter next state; a count change always (re)starts a conversion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (changed_s) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (changed_s) begin
                    state_d = ST_SHIFT;
                end else if (idx_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Converter datapath and outputs; bcd only moves when a conversion completes.
    always_comb begin
        snap_d  = snap_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
        bcd_d   = bcd_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE, ST_SHIFT: begin
                if (changed_s) begin
                    snap_d  = cnt_q;
                    sr_d    = '0;
                    idx_d   = IDX_TOP;
                    valid_d = 1'b0;
                end else if (state_q == ST_SHIFT) begin
                    sr_d = shifted_s;
                    if (idx_q == '0) begin
                        bcd_d   = shifted_s;
                        valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q - IW'(1);
                    end
                end else begin
                    valid_d = valid_q;
                end
            end
            default: begin
                valid_d = valid_q;
            end
        endcase
    end

    // Converter datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_q  <= '0;
            sr_q    <= '0;
            idx_q   <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b1;
        end else begin
            snap_q  <= snap_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
        end
    end

    assign count     = cnt_q;
    assign tc        = tc_q;
    assign bcd       = bcd_q;
    assign bcd_valid = valid_q;

endmodule

// File: tb/tb_modn_counter_bcd.sv
// Bench for modn_counter_bcd: two instances (prescale 1 and 4) share stimulus and
// are checked every cycle against a behavioural model, plus directed literals.
module tb_modn_counter_bcd;

    localparam int W = 8;
    localparam int M = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [1:0]  mode;
    logic [7:0]  load_val;
    logic [7:0]  count1, count4;
    logic        tc1, tc4;
    logic [11:0] bcd1, bcd4;
    logic        v1, v4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    modn_counter_bcd #(.WIDTH(8), .MODULUS(200), .DIGITS(3), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .load_val(load_val),
        .count(count1), .tc(tc1), .bcd(bcd1), .bcd_valid(v1)
    );

    modn_counter_bcd #(.WIDTH(8), .MODULUS(200), .DIGITS(3), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .load_val(load_val),
        .count(count4), .tc(tc4), .bcd(bcd4), .bcd_valid(v4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int pval(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Model: count from the mode rules; bcd is valid once the count has been
    // constant over the last W+1 sampled cycles, and otherwise holds its old value.
    int   m_cnt [2];
    int   m_pre [2];
    int   m_bcd [2];
    logic m_tc  [2];
    logic m_valid [2];
    int   m_hist [2][W+1];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i]   <= 0;
                m_pre[i]   <= 0;
                m_bcd[i]   <= 0;
                m_tc[i]    <= 1'b0;
                m_valid[i] <= 1'b1;
                for (int k = 0; k <= W; k++) m_hist[i][k] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                automatic int   nc = m_cnt[i];
                automatic int   np = m_pre[i];
                automatic logic ntc = 1'b0;
                automatic logic all_eq = 1'b1;
                if (mode == 2'b11) begin
                    nc = (int'(load_val) > M - 1) ? M - 1 : int'(load_val);
                    np = 0;
                end else if (en && (mode == 2'b01 || mode == 2'b10)) begin
                    if (np == pval(i) - 1) begin
                        np = 0;
                        if (mode == 2'b01) begin
                            if (nc == M - 1) begin nc = 0; ntc = 1'b1; end
                            else nc = nc + 1;
                        end else begin
                            if (nc == 0) begin nc = M - 1; ntc = 1'b1; end
                            else nc = nc - 1;
                        end
                    end else begin
                        np = np + 1;
                    end
                end
                for (int k = 1; k <= W; k++) begin
                    if (m_hist[i][k] != m_hist[i][0]) all_eq = 1'b0;
                end
                if (all_eq || (m_valid[i] && m_hist[i][0] == m_bcd[i])) begin
                    m_valid[i] <= 1'b1;
                    m_bcd[i]   <= m_hist[i][0];
                end else begin
                    m_valid[i] <= 1'b0;
                end
                m_cnt[i] <= nc;
                m_pre[i] <= np;
                m_tc[i]  <= ntc;
                for (int k = W; k >= 1; k--) m_hist[i][k] <= m_hist[i][k-1];
                m_hist[i][0] <= nc;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("count_p1", count1, m_cnt[0]);
            chk("tc_p1",    tc1,    m_tc[0]);
            chk("bcd_p1",   bcd1,   to_bcd(m_bcd[0]));
            chk("valid_p1", v1,     m_valid[0]);
            chk("count_p4", count4, m_cnt[1]);
            chk("tc_p4",    tc4,    m_tc[1]);
            chk("bcd_p4",   bcd4,   to_bcd(m_bcd[1]));
            chk("valid_p4", v4,     m_valid[1]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] md, input logic e, input logic [7:0] lv);
        mode = md;
        en = e;
        load_val = lv;
    endtask

    initial begin
        reset = 1'b1;
        drive(2'b00, 1'b0, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_count", count1, 32'd0);
        chk("rst_tc",    tc1,    32'd0);
        chk("rst_bcd",   bcd1,   32'h000);
        chk("rst_valid", v1,     32'd1);

        // Reset in the middle of a conversion, with no clock edge.
        cyc(1);
        drive(2'b11, 1'b0, 8'd150); cyc(1);
        chk("load150", count1, 32'd150);
        drive(2'b00, 1'b0, 8'd0); cyc(4);
        chk("busy150", v1, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_count", count1, 32'd0);
        chk("mid_rst_tc",    tc1,    32'd0);
        chk("mid_rst_bcd",   bcd1,   32'h000);
        chk("mid_rst_valid", v1,     32'd1);
        #1 reset = 1'b0;
        cyc(1);

        // Up wrap 199 -> 0.
        drive(2'b11, 1'b0, 8'd199); cyc(1);
        drive(2'b01, 1'b1, 8'd0); cyc(1);
        chk("upwrap_count", count1, 32'd0);
        chk("upwrap_tc",    tc1,    32'd1);
        drive(2'b00, 1'b0, 8'd0); cyc(1);
        chk("upwrap_tc_off", tc1, 32'd0);
        chk("upwrap_busy",   v1,  32'd0);
        cyc(7);
        chk("upwrap_busy8", v1, 32'd0);
        cyc(1);
        chk("upwrap_bcd",   bcd1, 32'h000);
        chk("upwrap_valid", v1,   32'd1);

        // Down wrap 0 -> 199, then down/up toggling gives back-to-back tc.
        drive(2'b11, 1'b0, 8'd0); cyc(1);
        drive(2'b10, 1'b1, 8'd0); cyc(1);
        chk("dnwrap_count", count1, 32'd199);
        chk("dnwrap_tc",    tc1,    32'd1);
        drive(2'b01, 1'b1, 8'd0); cyc(1);
        chk("toggle_count", count1, 32'd0);
        chk("toggle_tc",    tc1,    32'd1);
        drive(2'b10, 1'b1, 8'd0); cyc(1);
        chk("toggle2_count", count1, 32'd199);
        chk("toggle2_tc",    tc1,    32'd1);
        drive(2'b00, 1'b0, 8'd0); cyc(1);
        chk("hold_tc", tc1, 32'd0);
        cyc(7);
        chk("dn_busy8", v1, 32'd0);
        cyc(1);
        chk("dn_bcd",   bcd1, 32'h199);
        chk("dn_valid", v1,   32'd1);

        // Load clamp, then a plain load.
        drive(2'b11, 1'b0, 8'd250); cyc(1);
        chk("clamp_count", count1, 32'd199);
        drive(2'b11, 1'b0, 8'd42); cyc(1);
        chk("load42_count", count1, 32'd42);
        drive(2'b00, 1'b0, 8'd0); cyc(8);
        chk("load42_busy8", v1, 32'd0);
        cyc(1);
        chk("load42_bcd",   bcd1, 32'h042);
        chk("load42_valid", v1,   32'd1);

        // Prescaler on the PRESCALE=4 instance.
        drive(2'b11, 1'b0, 8'd5); cyc(1);
        chk("p4_load", count4, 32'd5);
        drive(2'b01, 1'b1, 8'd0); cyc(3);
        chk("p4_edge3", count4, 32'd5);
        cyc(1);
        chk("p4_edge4", count4, 32'd6);
        cyc(4);
        chk("p4_edge8", count4, 32'd7);
        cyc(2);
        drive(2'b01, 1'b0, 8'd0); cyc(3);
        chk("p4_paused", count4, 32'd7);
        drive(2'b01, 1'b1, 8'd0); cyc(1);
        chk("p4_resume1", count4, 32'd7);
        cyc(1);
        chk("p4_resume2", count4, 32'd8);
        chk("p1_running", count1, 32'd17);

        // Continuous counting keeps aborting the conversion.
        drive(2'b11, 1'b0, 8'd0); cyc(1);
        drive(2'b01, 1'b1, 8'd0);
        for (int n = 0; n < 20; n++) begin
            cyc(1);
            chk("abort_valid", v1, 32'd0);
        end
        chk("abort_count", count1, 32'd20);
        drive(2'b00, 1'b0, 8'd0); cyc(8);
        chk("abort_busy8", v1, 32'd0);
        cyc(1);
        chk("abort_bcd",   bcd1, 32'h020);
        chk("abort_valid_end", v1, 32'd1);

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
